ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle control sequencer that drives the single-cycle datapath. It decodes the datapath's `op[5:0]` and `zero` outputs and produces every datapath control strobe, including the register, memory, ALU, PC-select, call/return and `halt` signals. `halt` is used as a PC-hold stall, so each instruction occupies 2–4 controller cycles. Register and memory write strobes are asserted only in an instruction's final state.

## Interface
Parameters:
- `ALU_ADD`, 5'b00000: ALUOp code used for LW/SW address generation.
- `ALU_SUB`, 5'b00001: ALUOp code used for BEQ/BNE compare.

Ports:
- `clk`  in  1  clock; controller state changes on posedge; datapath acts on negedge.
- `reset`  in  1  reset, synchronous, active-high.
- `op`  in  6  opcode from the datapath, instr[31:26].
- `zero`  in  1  ALU zero flag from the datapath.
- `RegDst`, `ALUSrc`, `Mem2Reg`, `MemRead`, `MemWrite`, `RegWrite`, `PCSrc`, `push`, `pop`  out  1 each  datapath strobes.
- `ALUOp`  out  5  ALU function select.
- `halt`  out  1  1 = hold PC, stack and pc_buff.
- `halted`  out  1  HALT instruction retired.
- `instr_count`  out  16  retired-instruction counter.

## Operation
- **States:** START, DECODE, EXEC, MEM, WB, BR, STOP (3-bit encoding).
- **Opcode latch:** `ir_op` captures `op` on the posedge leaving DECODE. All outputs are a function of state and `ir_op` only (Moore), never of live `op`.
- **Opcode classes:**
  - **R-ALU:** op[5:4]=00. ALUOp={0,op[3:0]}, RegDst=1, ALUSrc=0.
  - **I-ALU:** op[5:4]=01. ALUOp={0,op[3:0]}, RegDst=0, ALUSrc=1.
  - **LW** 100000, **SW** 100001: ALUSrc=1, ALUOp=ALU_ADD.
  - **BEQ** 100010, **BNE** 100011: ALUSrc=0, ALUOp=ALU_SUB.
  - **CALL** 100100, **JMP** 100110, **RET** 100101.
  - **HALT** 111111.
  - **NOP:** any other opcode.
- **Sequences** (final state shown last; each strobe is listed in the state where it asserts):
  - R/I-ALU: DECODE→EXEC→WB. WB: RegWrite=1, Mem2Reg=0.
  - LW: DECODE→EXEC→MEM→WB. MemRead=1 in MEM and WB. WB: RegWrite=1, Mem2Reg=1.
  - SW: DECODE→EXEC→MEM. MEM: MemWrite=1.
  - BEQ/BNE: DECODE→EXEC→BR. `zero` is sampled into `taken` at the EXEC→BR posedge. BR: PCSrc = taken (BEQ) or ~taken (BNE).
  - JMP: DECODE→BR, PCSrc=1.
  - CALL: DECODE→BR, PCSrc=1, push=1.
  - RET: DECODE→BR, pop=1.
  - NOP: DECODE→WB, all strobes 0.
  - HALT: DECODE→STOP. STOP is held until reset; `halted`=1.
- **halt output:** 0 only in START and in each final state; 1 in all other states, including STOP.
- **Operand selects:** ALUOp, ALUSrc and RegDst hold their class value from EXEC through the final state. They are 0 in DECODE, START and STOP.
- **START:** one cycle after reset with halt=0 and all strobes 0, so the datapath PC steps from -4 to 0. START→DECODE.
- **After a final state:** next state is DECODE.
- **instr_count:** +1 on each final-state posedge (STOP entry counts once). Wraps 0xFFFF→0x0000.

## Timing
- **Reset values:** all strobes 0, ALUOp=0, halt=1, halted=0, instr_count=0, ir_op=0. State becomes START on the first posedge with reset=0.
- **Reset mid-instruction:** takes priority in any state, including STOP. No partial write strobe may follow the reset posedge.
- **Output timing:** outputs change only at posedge and are stable for the datapath's negedge half a cycle later.
- **CPI:** ALU 3, LW 4, SW 3, branch 3, JMP/CALL/RET 2, NOP 2.
- **Exclusivity:** push and pop are never both 1. MemRead and MemWrite are never both 1.
- **Branch compare:** `zero` is ignored except at the EXEC→BR edge.

## Test plan
- **Reset release:** reset high 2 cycles, then low. Required: halt=1 during reset; START lasts 1 cycle with halt=0; DECODE follows; instr_count=0.
- **R-type:** op=000010. Required: DECODE, EXEC, WB. ALUOp=00010 and RegDst=1 in EXEC/WB. RegWrite=1 only in WB. instr_count 0→1.
- **LW then SW:** Required: LW spans 4 cycles with MemRead=1 in MEM/WB and Mem2Reg=1 in WB. SW spans 3 cycles with MemWrite=1 only in MEM, ALUOp=00000, ALUSrc=1.
- **BEQ/BNE:** zero=1 at EXEC→BR. Required: PCSrc=1 in BR for BEQ and 0 for BNE. Repeat with zero=0: results invert.
- **CALL then RET, HALT:** Required: push=1 in CALL's BR cycle; pop=1 in RET's BR cycle. HALT enters STOP with halted=1 and halt=1 held 20+ cycles; instr_count increments exactly once for HALT.
- **Reset in MEM of SW; wrap:** Required: reset in MEM of SW gives MemWrite=0 from the reset edge and a return to START. Forcing instr_count=0xFFFF and retiring a NOP gives 0x0000.

Source files
------------

// File: rtl/ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_if : bundle between the multi-cycle control sequencer and the
// single-cycle datapath.
//   op[5:0], zero           datapath -> controller (opcode, ALU zero flag)
//   RegDst .. pop, ALUOp    controller -> datapath control strobes
//   halt                    controller -> datapath PC/stack/pc_buff hold
//   halted, instr_count     controller status (HALT retired, retire count)
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface ctrl_fsm_if;
  logic [5:0]  op;
  logic        zero;
  logic        RegDst;
  logic        ALUSrc;
  logic        Mem2Reg;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        PCSrc;
  logic        push;
  logic        pop;
  logic [4:0]  ALUOp;
  logic        halt;
  logic        halted;
  logic [15:0] instr_count;

  modport master (
    input  op, zero,
    output RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite,
           PCSrc, push, pop, ALUOp, halt, halted, instr_count
  );

  modport slave (
    output op, zero,
    input  RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite,
           PCSrc, push, pop, ALUOp, halt, halted, instr_count
  );
endinterface

// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm : multi-cycle control sequencer for the single-cycle datapath.
// Each instruction takes 2-4 controller cycles; halt stalls the PC on every
// non-final cycle. Outputs are Moore (state + latched opcode), registered at
// posedge so the datapath sees stable strobes on its negedge.
// Ports:
//   clk    in  clock (controller acts on posedge)
//   reset  in  synchronous, active-high reset
//   bus    ctrl_fsm_if.master : op/zero in; strobes, ALUOp, halt,
//          halted, instr_count out
// ---------------------------------------------------------------------------
module ctrl_fsm #(
  parameter logic [4:0] ALU_ADD = 5'b00000,
  parameter logic [4:0] ALU_SUB = 5'b00001
) (
  input  logic       clk,
  input  logic       reset,
  ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_CALL, C_RET, C_JMP, C_HALT, C_NOP
  } class_e;

  function automatic class_e f_class(input logic [5:0] o);
    class_e c;
    if (o[5:4] == 2'b00)      c = C_R;
    else if (o[5:4] == 2'b01) c = C_I;
    else begin
      case (o)
        6'b100000: c = C_LW;
        6'b100001: c = C_SW;
        6'b100010: c = C_BEQ;
        6'b100011: c = C_BNE;
        6'b100100: c = C_CALL;
        6'b100101: c = C_RET;
        6'b100110: c = C_JMP;
        6'b111111: c = C_HALT;
        default:   c = C_NOP;
      endcase
    end
    return c;
  endfunction

  state_e      r_state;
  logic [5:0]  r_ir_op;
  logic        r_taken;
  logic        r_boot;     // set while reset is held; keeps halt=1 in START
  logic [15:0] r_instr_count;

  state_e      w_nxt;
  class_e      w_cls;      // class of the latched opcode
  class_e      w_dec_cls;  // class of the live opcode, used only in DECODE
  logic        w_retire;
  logic        w_sel;
  logic        w_final;

  assign w_cls     = f_class(r_ir_op);
  assign w_dec_cls = f_class(bus.op);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_START;
      r_boot        <= 1'b1;
      r_ir_op       <= 6'd0;
      r_taken       <= 1'b0;
      r_instr_count <= 16'd0;
    end else begin
      r_state <= w_nxt;
      r_boot  <= 1'b0;
      if (r_state == S_DECODE) r_ir_op <= bus.op;
      if (r_state == S_EXEC)   r_taken <= bus.zero;
      if (w_retire)            r_instr_count <= r_instr_count + 16'd1;
    end
  end

  // Next-state logic; DECODE branches on the live opcode because the latch
  // only captures it on the edge leaving DECODE.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_START:  w_nxt = r_boot ? S_START : S_DECODE;
      S_DECODE: begin
        case (w_dec_cls)
          C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE: w_nxt = S_EXEC;
          C_CALL, C_RET, C_JMP:               w_nxt = S_BR;
          C_HALT:                             w_nxt = S_STOP;
          default:                            w_nxt = S_WB;
        endcase
      end
      S_EXEC: begin
        case (w_cls)
          C_LW, C_SW:   w_nxt = S_MEM;
          C_BEQ, C_BNE: w_nxt = S_BR;
          default:      w_nxt = S_WB;
        endcase
      end
      S_MEM:        w_nxt = (w_cls == C_LW) ? S_WB : S_DECODE;
      S_WB, S_BR:   w_nxt = S_DECODE;
      S_STOP:       w_nxt = S_STOP;
      default:      w_nxt = S_START;
    endcase
  end

  // An instruction retires on the edge that enters its final state; STOP is
  // entered only from DECODE, so HALT counts exactly once.
  assign w_retire = (w_nxt == S_WB) || (w_nxt == S_BR) ||
                    ((r_state == S_EXEC) && (w_nxt == S_MEM) && (w_cls == C_SW)) ||
                    ((r_state == S_DECODE) && (w_nxt == S_STOP));

  assign w_sel   = (r_state == S_EXEC) || (r_state == S_MEM) ||
                   (r_state == S_WB)   || (r_state == S_BR);
  assign w_final = (r_state == S_WB) || (r_state == S_BR) ||
                   ((r_state == S_MEM) && (w_cls == C_SW));

  // Moore outputs
  always_comb begin
    bus.RegDst      = 1'b0;
    bus.ALUSrc      = 1'b0;
    bus.Mem2Reg     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.PCSrc       = 1'b0;
    bus.push        = 1'b0;
    bus.pop         = 1'b0;
    bus.ALUOp       = 5'd0;
    bus.halt        = r_boot || !((r_state == S_START) || w_final);
    bus.halted      = (r_state == S_STOP);
    bus.instr_count = r_instr_count;

    if (w_sel) begin
      case (w_cls)
        C_R: begin
          bus.ALUOp  = {1'b0, r_ir_op[3:0]};
          bus.RegDst = 1'b1;
        end
        C_I: begin
          bus.ALUOp  = {1'b0, r_ir_op[3:0]};
          bus.ALUSrc = 1'b1;
        end
        C_LW, C_SW: begin
          bus.ALUOp  = ALU_ADD;
          bus.ALUSrc = 1'b1;
        end
        C_BEQ, C_BNE: bus.ALUOp = ALU_SUB;
        default: ;
      endcase
    end

    case (r_state)
      S_MEM: begin
        bus.MemRead  = (w_cls == C_LW);
        bus.MemWrite = (w_cls == C_SW);
      end
      S_WB: begin
        bus.RegWrite = (w_cls == C_R) || (w_cls == C_I) || (w_cls == C_LW);
        bus.Mem2Reg  = (w_cls == C_LW);
        bus.MemRead  = (w_cls == C_LW);
      end
      S_BR: begin
        bus.PCSrc = (w_cls == C_JMP) || (w_cls == C_CALL) ||
                    ((w_cls == C_BEQ) && r_taken) ||
                    ((w_cls == C_BNE) && !r_taken);
        bus.push  = (w_cls == C_CALL);
        bus.pop   = (w_cls == C_RET);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_fsm_if b ();
  ctrl_fsm #(.ALU_ADD(5'b00000), .ALU_SUB(5'b00001)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  localparam logic [5:0] OP_LW = 6'b100000, OP_SW = 6'b100001, OP_BEQ = 6'b100010,
                         OP_BNE = 6'b100011, OP_CALL = 6'b100100, OP_RET = 6'b100101,
                         OP_JMP = 6'b100110, OP_HALT = 6'b111111, OP_NOP = 6'b101000;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] sb[$];

  // {halt,halted,RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc,push,pop,ALUOp}
  function automatic logic [15:0] ev(bit h, bit hd, bit rd, bit as, bit m2r, bit mr,
                                     bit mw, bit rw, bit pc, bit pu, bit po,
                                     logic [4:0] aop);
    return {h, hd, rd, as, m2r, mr, mw, rw, pc, pu, po, aop};
  endfunction

  localparam logic [15:0] E_HALT_ONLY = 16'h8000;  // halt=1, everything else 0
  localparam logic [15:0] E_IDLE      = 16'h0000;  // START / final with no strobes

  // Drive inputs for one cycle, queue the outputs expected after the next
  // posedge, then check them on the following negedge.
  task automatic cyc(input string tag, input logic [5:0] o, input logic z,
                     input logic [15:0] e, input bit inc);
    logic [31:0] exp_w;
    logic [15:0] obs;
    b.op = o;
    b.zero = z;
    if (inc) exp_cnt = exp_cnt + 16'd1;
    sb.push_back({e, exp_cnt});
    @(posedge clk);
    @(negedge clk);
    exp_w = sb.pop_front();
    obs = {b.halt, b.halted, b.RegDst, b.ALUSrc, b.Mem2Reg, b.MemRead, b.MemWrite,
           b.RegWrite, b.PCSrc, b.push, b.pop, b.ALUOp};
    n_total++;
    assert (obs === exp_w[31:16]) n_pass++;
    else $error("FAIL %s strobes got=%h exp=%h", tag, obs, exp_w[31:16]);
    n_total++;
    assert (b.instr_count === exp_w[15:0]) n_pass++;
    else $error("FAIL %s instr_count got=%h exp=%h", tag, b.instr_count, exp_w[15:0]);
    n_total++;
    assert ({b.push & b.pop, b.MemRead & b.MemWrite} === 2'b00) n_pass++;
    else $error("FAIL %s exclusivity got=%b exp=00", tag, {b.push & b.pop, b.MemRead & b.MemWrite});
  endtask

  task automatic do_alu(input logic [5:0] o);
    bit r = (o[5:4] == 2'b00);
    logic [4:0] a = {1'b0, o[3:0]};
    cyc("alu_exec", o, 1'b0, ev(1,0,r,!r,0,0,0,0,0,0,0,a), 0);
    cyc("alu_wb",   o, 1'b0, ev(0,0,r,!r,0,0,0,1,0,0,0,a), 1);
    cyc("alu_dec",  o, 1'b0, E_HALT_ONLY, 0);
  endtask

  task automatic do_lw();
    cyc("lw_exec", OP_LW, 1'b0, ev(1,0,0,1,0,0,0,0,0,0,0,5'd0), 0);
    cyc("lw_mem",  OP_LW, 1'b0, ev(1,0,0,1,0,1,0,0,0,0,0,5'd0), 0);
    cyc("lw_wb",   OP_LW, 1'b0, ev(0,0,0,1,1,1,0,1,0,0,0,5'd0), 1);
    cyc("lw_dec",  OP_LW, 1'b0, E_HALT_ONLY, 0);
  endtask

  task automatic do_br(input logic [5:0] o, input logic z);
    bit pc = (o == OP_BEQ) ? z : !z;
    // zero is driven opposite outside the EXEC cycle; it must be ignored there.
    cyc("br_exec", o, !z, ev(1,0,0,0,0,0,0,0,0,0,0,5'd1), 0);
    cyc("br_br",   o,  z, ev(0,0,0,0,0,0,0,0,pc,0,0,5'd1), 1);
    cyc("br_dec",  o, !z, E_HALT_ONLY, 0);
  endtask

  task automatic do_jump(input logic [5:0] o);
    bit c = (o == OP_CALL);
    bit r = (o == OP_RET);
    cyc("jmp_br",  o, 1'b1, ev(0,0,0,0,0,0,0,0,!r,c,r,5'd0), 1);
    cyc("jmp_dec", o, 1'b1, E_HALT_ONLY, 0);
  endtask

  task automatic do_reset_release();
    reset = 1'b1;
    exp_cnt = 16'd0;
    cyc("rst0", OP_NOP, 1'b0, E_HALT_ONLY, 0);
    cyc("rst1", OP_NOP, 1'b0, E_HALT_ONLY, 0);
    reset = 1'b0;
    cyc("start",  OP_NOP, 1'b0, E_IDLE, 0);
    cyc("decode", OP_NOP, 1'b0, E_HALT_ONLY, 0);
  endtask

  initial begin
    reset = 1'b1;
    b.op = 6'd0;
    b.zero = 1'b0;
    @(negedge clk);

    do_reset_release();
    do_alu(6'b000010);          // R-type
    do_alu(6'b010111);          // I-type
    do_lw();
    cyc("sw_exec", OP_SW, 1'b0, ev(1,0,0,1,0,0,0,0,0,0,0,5'd0), 0);
    cyc("sw_mem",  OP_SW, 1'b0, ev(0,0,0,1,0,0,1,0,0,0,0,5'd0), 1);
    cyc("sw_dec",  OP_SW, 1'b0, E_HALT_ONLY, 0);
    do_br(OP_BEQ, 1'b1);
    do_br(OP_BNE, 1'b1);
    do_br(OP_BEQ, 1'b0);
    do_br(OP_BNE, 1'b0);
    do_jump(OP_CALL);
    do_jump(OP_RET);
    do_jump(OP_JMP);
    cyc("nop_wb",  OP_NOP, 1'b0, E_IDLE, 1);
    cyc("nop_dec", OP_NOP, 1'b0, E_HALT_ONLY, 0);

    // Counter wrap: preload 0xFFFF while in DECODE, then retire a NOP.
    force dut.r_instr_count = 16'hFFFF;
    #1 release dut.r_instr_count;
    exp_cnt = 16'hFFFF;
    cyc("wrap_wb",  OP_NOP, 1'b0, E_IDLE, 1);
    cyc("wrap_dec", OP_NOP, 1'b0, E_HALT_ONLY, 0);

    // HALT: STOP holds with halt=1, halted=1, counted once.
    cyc("halt_stop", OP_HALT, 1'b0, ev(1,1,0,0,0,0,0,0,0,0,0,5'd0), 1);
    for (int i = 0; i < 22; i++)
      cyc("halt_hold", (i % 2 == 0) ? OP_LW : OP_CALL, 1'b1,
          ev(1,1,0,0,0,0,0,0,0,0,0,5'd0), 0);

    // Reset out of STOP, then reset during SW's MEM cycle.
    do_reset_release();
    cyc("sw2_exec", OP_SW, 1'b0, ev(1,0,0,1,0,0,0,0,0,0,0,5'd0), 0);
    cyc("sw2_mem",  OP_SW, 1'b0, ev(0,0,0,1,0,0,1,0,0,0,0,5'd0), 1);
    reset = 1'b1;
    exp_cnt = 16'd0;
    cyc("sw2_rst", OP_SW, 1'b0, E_HALT_ONLY, 0);
    reset = 1'b0;
    cyc("sw2_start",  OP_SW, 1'b0, E_IDLE, 0);
    cyc("sw2_decode", OP_SW, 1'b0, E_HALT_ONLY, 0);
    do_alu(6'b000001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
